// File: rtl/fb_pipereg_if.sv
// Handshake bundle between two pipeline stages: upstream payload in, downstream payload out.
interface fb_pipereg_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // The pipeline register itself.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    // Whatever sits around the register: the producer and the consumer.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fb_pipereg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and a saturating stall counter for performance debug.
module fb_pipereg #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned SKID           = 1,
    parameter int unsigned CLEAR_ON_FLUSH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    fb_pipereg_if.slave bus,
    input  logic        flush,
    input  logic        clr_stats,
    output logic [1:0]  occupancy,
    output logic [15:0] stall_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e            r_state;
    logic              r_main_vld;
    logic              r_in_rdy;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;   // holds a live entry exactly when r_state == StTwo
    logic [15:0]       r_stall;

    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;

    // Handshake decode; with a skid buffer in_ready comes straight from a flop.
    always_comb begin
        w_in_ready = (SKID != 0) ? r_in_rdy : (!r_main_vld || bus.out_ready);
        w_in_fire  = bus.in_valid && w_in_ready;
        w_out_fire = r_main_vld && bus.out_ready;
    end

    // in_ready is held low while reset is asserted, independent of the flops.
    assign bus.in_ready  = w_in_ready && rst_n;
    assign bus.out_valid = r_main_vld;
    assign bus.out_data  = r_main;
    assign occupancy     = r_state;
    assign stall_cnt     = r_stall;

    // Occupancy FSM with main/skid storage; flush wins over any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StEmpty;
            r_main_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (flush) begin
            // An out_fire this cycle still completes; an in_fire is dropped.
            r_state    <= StEmpty;
            r_main_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
            if (CLEAR_ON_FLUSH != 0) begin
                r_main <= '0;
                r_skid <= '0;
            end
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_in_fire) begin
                        r_main     <= bus.in_data;
                        r_main_vld <= 1'b1;
                        r_state    <= StOne;
                    end
                end
                StOne: begin
                    // Without a skid buffer an in_fire while full implies an out_fire.
                    if (w_in_fire && (w_out_fire || SKID == 0)) begin
                        r_main <= bus.in_data;
                    end else if (w_in_fire) begin
                        r_skid   <= bus.in_data;
                        r_state  <= StTwo;
                        r_in_rdy <= 1'b0;
                    end else if (w_out_fire) begin
                        r_main_vld <= 1'b0;
                        r_state    <= StEmpty;
                    end
                end
                StTwo: begin
                    if (w_out_fire) begin
                        r_main   <= r_skid;
                        r_state  <= StOne;
                        r_in_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= StEmpty;
                    r_main_vld <= 1'b0;
                    r_in_rdy   <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of cycles where the stage holds data the consumer will not take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (clr_stats) begin
            r_stall <= '0;
        end else if (r_main_vld && !bus.out_ready && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

endmodule

// File: tb/tb_fb_pipereg.sv
// Self-checking bench for fb_pipereg: scoreboard queue model for the skid variant plus
// directed checks of a pass-through (no skid, no clear-on-flush) variant.
module tb_fb_pipereg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        clr_stats;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic        flush0;
    logic        clr0;
    logic [1:0]  occ0;
    logic [15:0] stall0;

    fb_pipereg_if #(.DATA_W(32)) bus ();
    fb_pipereg_if #(.DATA_W(32)) bus0 ();

    fb_pipereg #(.DATA_W(32), .SKID(1), .CLEAR_ON_FLUSH(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .clr_stats (clr_stats),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    fb_pipereg #(.DATA_W(32), .SKID(0), .CLEAR_ON_FLUSH(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus0),
        .flush     (flush0),
        .clr_stats (clr0),
        .occupancy (occ0),
        .stall_cnt (stall0)
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Reference model: payloads held by the stage, oldest first, plus the stall count.
    logic [31:0] m_q[$];
    logic [15:0] m_stall = 16'd0;
    int          mon_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; pushes the payload into the scoreboard if the model accepts it.
    task automatic step(input logic v, input logic [31:0] d, input logic ordy, input logic fl,
                        input logic clr);
        logic acc;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        clr_stats     = clr;
        #1;
        acc = v && !fl && (m_q.size() < 2);
        @(posedge clk);
        #1;
        if (acc) m_q.push_back(d);
    endtask

    // Monitor: compares the presented outputs against the model, then retires them.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                m_q.delete();
                m_stall = 16'd0;
                check("rst_out_valid", 32'(bus.out_valid), 32'd0);
                check("rst_in_ready", 32'(bus.in_ready), 32'd0);
                check("rst_out_data", bus.out_data, 32'd0);
                check("rst_occupancy", 32'(occupancy), 32'd0);
                check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
            end else begin
                mon_n = m_q.size();
                check("out_valid", 32'(bus.out_valid), 32'(mon_n > 0));
                check("occupancy", 32'(occupancy), 32'(mon_n));
                check("in_ready", 32'(bus.in_ready), 32'(mon_n < 2));
                check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
                if (mon_n > 0) check("out_data", bus.out_data, m_q[0]);
                if (mon_n > 0 && bus.out_ready) void'(m_q.pop_front());
                if (flush) m_q.delete();
                if (clr_stats) m_stall = 16'd0;
                else if (mon_n > 0 && !bus.out_ready && m_stall != 16'hFFFF) m_stall++;
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
        flush = 1'b0; clr_stats = 1'b0; flush0 = 1'b0; clr0 = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("reset_occ", 32'(occupancy), 32'd0);
        check("reset_out_data", bus.out_data, 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        check("reset0_out_valid", 32'(bus0.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming at full rate.
        step(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
        check("stream_d1", bus.out_data, 32'h1);
        check("stream_occ1", 32'(occupancy), 32'd1);
        step(1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
        check("stream_d2", bus.out_data, 32'h2);
        step(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
        check("stream_d3", bus.out_data, 32'h3);
        check("stream_occ3", 32'(occupancy), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("stream_drain", 32'(bus.out_valid), 32'd0);
        check("stream_stall", 32'(stall_cnt), 32'd0);

        // Backpressure fills the skid entry.
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        check("bp_occ1", 32'(occupancy), 32'd1);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        check("bp_occ2", 32'(occupancy), 32'd2);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_hold_a", bus.out_data, 32'hA);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("bp_stall", 32'(stall_cnt), 32'd2);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("bp_out_b", bus.out_data, 32'hB);
        check("bp_ready_back", 32'(bus.in_ready), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("bp_empty", 32'(occupancy), 32'd0);

        // Flush while full, with a payload offered in the flush cycle.
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h12, 1'b0, 1'b0, 1'b0);
        check("fl_full", 32'(occupancy), 32'd2);
        step(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
        check("fl_occ", 32'(occupancy), 32'd0);
        check("fl_valid", 32'(bus.out_valid), 32'd0);
        check("fl_cleared", bus.out_data, 32'd0);
        step(1'b1, 32'h13, 1'b1, 1'b0, 1'b0);
        check("fl_next", bus.out_data, 32'h13);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
        end

        // Asynchronous reset while holding two entries.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        check("ar_full", 32'(occupancy), 32'd2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(bus.out_valid), 32'd0);
        check("ar_in_ready", 32'(bus.in_ready), 32'd0);
        check("ar_out_data", bus.out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h31, 1'b1, 1'b0, 1'b0);
        check("ar_first_valid", 32'(bus.out_valid), 32'd1);
        check("ar_first_data", bus.out_data, 32'h31);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Stall counter saturation and clear.
        step(1'b1, 32'h41, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("sat_ffff", 32'(stall_cnt), 32'hFFFF);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("sat_clear", 32'(stall_cnt), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("sat_restart", 32'(stall_cnt), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Pass-through variant: combinational ready, single entry, stale data on flush.
        @(negedge clk);
        bus0.in_valid = 1'b1; bus0.in_data = 32'h51; bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        check("p0_first", bus0.out_data, 32'h51);
        check("p0_occ", 32'(occ0), 32'd1);
        @(negedge clk);
        bus0.in_data = 32'h52;
        @(posedge clk); #1;
        check("p0_rate", bus0.out_data, 32'h52);
        @(negedge clk);
        bus0.in_data = 32'h53; bus0.out_ready = 1'b0;
        #1;
        check("p0_blocked", 32'(bus0.in_ready), 32'd0);
        @(posedge clk); #1;
        check("p0_hold", bus0.out_data, 32'h52);
        @(negedge clk);
        bus0.out_ready = 1'b1;
        #1;
        check("p0_ready_same", 32'(bus0.in_ready), 32'd1);
        @(posedge clk); #1;
        check("p0_replace", bus0.out_data, 32'h53);
        check("p0_occ_max", 32'(occ0), 32'd1);
        @(negedge clk);
        flush0 = 1'b1; bus0.in_data = 32'h5C; bus0.out_ready = 1'b0;
        @(posedge clk); #1;
        check("p0_fl_occ", 32'(occ0), 32'd0);
        check("p0_fl_valid", 32'(bus0.out_valid), 32'd0);
        check("p0_fl_stale", bus0.out_data, 32'h53);
        @(negedge clk);
        flush0 = 1'b0; bus0.in_valid = 1'b0;
        @(posedge clk); #1;
        check("p0_fl_gone", 32'(bus0.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_pipereg.md
# fb_pipereg

Parametrised pipeline stage register replacing the fixed-field, write-enable-only inter-stage registers (IF/ID … MEM/WB) with one generic block. It carries an opaque payload with a valid/ready handshake, an optional two-entry skid buffer for registered backpressure, a synchronous flush for branch and exception squashing, and a saturating stall counter for performance debug. Each pipeline boundary instantiates one copy, with its stage fields concatenated into `in_data`.

## Interface
- `DATA_W`, default 32: payload width in bits; legal range is 1..256.
- `SKID`, default 1:
  - 1 gives a two-entry skid buffer with `in_ready` driven from a register.
  - 0 gives a single entry, with `in_ready` combinational from `out_ready`.
- `CLEAR_ON_FLUSH`, default 1:
  - 1 zeroes the data registers on flush.
  - 0 holds their stale contents.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; one clock, reset is asynchronous and active-low.
- `in_valid` in 1: upstream stage holds a valid payload.
- `in_ready` out 1: this stage accepts the payload this cycle.
- `in_data` in DATA_W: upstream payload.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream consumes `out_data` this cycle.
- `out_data` out DATA_W: payload presented to the next stage.
- `flush` in 1: synchronous squash of all held and incoming entries.
- `clr_stats` in 1: synchronous clear of `stall_cnt`.
- `occupancy` out 2: number of entries held (0..2; never exceeds 1 when `SKID`=0).
- `stall_cnt` out 16: count of cycles with `out_valid`=1 and `out_ready`=0, saturating.

## Operation
- Handshake definitions:
  - Input fire (`in_fire`) = `in_valid` and `in_ready`.
  - Output fire (`out_fire`) = `out_valid` and `out_ready`.
  - Payloads leave in acceptance order; none is lost or duplicated except by `flush`.
- Storage:
  - `main` is a register with a valid bit; it drives `out_data` and `out_valid` directly.
  - `skid` is a register with a valid bit; it exists only when `SKID`=1.
- State machine, `SKID`=1. States: EMPTY (occ 0), ONE (occ 1), TWO (occ 2).
  - EMPTY: on `in_fire`, load `main` and go to ONE.
  - ONE, `in_fire` and `out_fire`: load `main` from input; stay in ONE.
  - ONE, `in_fire` only: load `skid`; go to TWO.
  - ONE, `out_fire` only: go to EMPTY.
  - ONE, neither: hold.
  - TWO: on `out_fire`, load `main` from `skid` and go to ONE; otherwise hold.
  - `in_ready` = (state ≠ TWO); this is a registered decode with no path from `out_ready`.
- State machine, `SKID`=0. States: EMPTY and ONE only.
  - `in_ready` = not `out_valid`, or `out_ready`.
  - On `in_fire`, load `main`.
  - On `out_fire` without `in_fire`, go to EMPTY.
- Flush:
  - `flush` has highest priority: next state is EMPTY and both valid bits clear.
  - An `in_fire` in the flush cycle is discarded.
  - An `out_fire` in the flush cycle still completes downstream, because that data was already presented.
  - With `CLEAR_ON_FLUSH`=1, `main` and `skid` data are set to 0. With `CLEAR_ON_FLUSH`=0, data is held.
- `stall_cnt`:
  - Increments by 1 on each cycle with `out_valid`=1 and `out_ready`=0.
  - Saturates at 0xFFFF.
  - `clr_stats` forces it to 0 and takes priority over the increment.
  - `flush` does not affect it.
- `occupancy` equals the state encoding: 0, 1 or 2.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State is EMPTY; `out_valid`=0; `out_data`=0; skid data=0; `occupancy`=0; `stall_cnt`=0.
  - `in_ready` is forced 0 while `rst_n` is low, and rises combinationally after release.
- Reset release takes effect at the first rising edge with `rst_n` high.
- Latency: a payload accepted at edge N appears on `out_data` with `out_valid`=1 after edge N, i.e. one cycle.
- Throughput is one payload per cycle when `out_ready` is held high, for either `SKID` setting.
- `SKID`=1: after `out_ready` deasserts, at most one further payload is accepted (into `skid`). `in_ready` drops in the cycle after the edge that fills `skid`.
- Reset asserted mid-transfer discards all entries immediately; no handshake completes on that edge.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- **Streaming.** `DATA_W`=32, `SKID`=1, `out_ready`=1. Drive 0x1, 0x2, 0x3 on consecutive cycles.
  - Required: `out_data` shows 0x1, 0x2, 0x3 on consecutive cycles starting one cycle later; `occupancy` stays ≤1; `stall_cnt`=0.
- **Backpressure into skid.** `out_ready`=0 while sending 0xA then 0xB.
  - Required: `occupancy`=2, `in_ready`=0, `out_data`=0xA held, and `stall_cnt` increments every cycle.
  - Then raise `out_ready`: outputs 0xA then 0xB, `in_ready` returns to 1, `occupancy` reaches 0.
- **Flush while full.** `occupancy`=2; assert `flush` with `in_valid`=1 and `in_data`=0xC.
  - Required next cycle: `occupancy`=0 and `out_valid`=0; `out_data`=0 when `CLEAR_ON_FLUSH`=1, stale 0xA when `CLEAR_ON_FLUSH`=0; 0xC is never output.
- **`SKID`=0 pass-through ready.** Hold a full stage with `out_ready`=0.
  - Required: `in_ready`=0. Raise `out_ready`: `in_ready`=1 in the same cycle, and the new payload replaces the old one at the next edge.
- **Counter saturation and clear.** Hold `out_valid`=1 and `out_ready`=0 for 70000 cycles.
  - Required: `stall_cnt`=0xFFFF and stays there.
  - Assert `clr_stats` together with a stall cycle: `stall_cnt`=0 on the next cycle.
- **Asynchronous reset mid-operation.** Assert `rst_n` low between clock edges while `occupancy`=2.
  - Required immediately: `out_valid`=0, `in_ready`=0, `out_data`=0.
  - After release: the first payload passes with one-cycle latency.
